// File: rtl/pulse_receiver_pkg.sv
// Shared definitions for the pulse receiver peripheral: FSM encodings, register
// offsets, CTRL/STATUS bit positions, register payload layouts and symbol geometry.
package pulse_receiver_pkg;

  // Receiver FSM encodings, also visible in STATUS[11:10]
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } rx_state_e;

  // Symbol geometry
  localparam int unsigned SYM_W         = 2;
  localparam int unsigned SYMS_PER_WORD = 16;

  // Register byte offsets
  localparam logic [5:0] ADDR_CTRL      = 6'h00;
  localparam logic [5:0] ADDR_THRESH    = 6'h04;
  localparam logic [5:0] ADDR_STATUS    = 6'h08;
  localparam logic [5:0] ADDR_DATA_BASE = 6'h20;

  // CTRL bit positions
  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_INV_BIT    = 1;
  localparam int unsigned CTRL_SEL_LSB    = 2;
  localparam int unsigned CTRL_INT_EN_BIT = 5;
  localparam int unsigned CTRL_PRESC_LSB  = 6;
  localparam int unsigned CTRL_W          = 10;

  // STATUS bit positions
  localparam int unsigned STATUS_DONE_BIT  = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_COUNT_LSB = 2;
  localparam int unsigned STATUS_STATE_LSB = 10;

  localparam int unsigned THRESH_W = 24;

  // CTRL payload, LSB first: enable, invert, sel, int_en, presc
  typedef struct packed {
    logic [3:0] presc;
    logic       int_en;
    logic [2:0] sel;
    logic       invert;
    logic       enable;
  } ctrl_t;

  // THRESH payload
  typedef struct packed {
    logic [7:0] idle_timeout;
    logic [7:0] high_thr;
    logic [7:0] low_thr;
  } thresh_t;

endpackage

// File: rtl/pulse_receiver_glitch_filter.sv
// Glitch filter for the selected input level: the output follows the input only
// after the input has differed from the output for GLITCH_CYCLES consecutive clocks.
// Ports:
//   clk      clock
//   rst_n    synchronous active-low reset (output resets to 0)
//   raw_in   unfiltered level
//   filt_out filtered level (registered)
module pulse_receiver_glitch_filter #(
  parameter int unsigned GLITCH_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic filt_out
);

  localparam int unsigned CNT_W = (GLITCH_CYCLES < 2) ? 1 : $clog2(GLITCH_CYCLES);

  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive disagreeing clocks; any agreement restarts the count
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (raw_in != filt_q) begin
      if (cnt_q == CNT_W'(GLITCH_CYCLES - 1)) begin
        filt_d = raw_in;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_out = filt_q;

endmodule

// File: rtl/tqvp_hx2003_pulse_receiver.sv
// TinyQV pulse receiver peripheral. Measures pulse widths on one selected ui_in pin,
// classifies each pulse into a 2-bit symbol {level, long} and packs the symbols into
// a CPU-readable data memory. Reception ends on idle timeout or full buffer, which
// sets STATUS.done and raises the interrupt when enabled.
// Optional glitch filter: define PULSE_RECEIVER_GLITCH_FILTER_EN.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   ui_in[7:0]      synchronised input pins; CTRL.sel picks the measured pin
//   uo_out[7:0]     unused, tied 0
//   address[5:0]    byte address within the peripheral
//   data_in[31:0]   write data; only 32-bit writes (data_write_n == 2'b10) act
//   data_write_n    write size strobe
//   data_read_n     unused; reads have no side effects
//   data_out[31:0]  combinational read mux
//   data_ready      always 1
//   user_interrupt  STATUS.done & CTRL.int_en
module tqvp_hx2003_pulse_receiver
  import pulse_receiver_pkg::*;
#(
  parameter int unsigned NUM_DATA_REG = 5
`ifdef PULSE_RECEIVER_GLITCH_FILTER_EN
  ,
  parameter int unsigned GLITCH_CYCLES = 4
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int unsigned CAPACITY = SYMS_PER_WORD * NUM_DATA_REG;
  localparam int unsigned COUNT_W  = 8;
  localparam int unsigned DUR_W    = 8;
  localparam int unsigned PRESC_W  = 15;

  ctrl_t               ctrl_q;
  thresh_t             thresh_q;
  rx_state_e           state_q, state_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic                full_q, full_d;
  logic                done_q, done_d;
  logic                prev_lvl_q;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [31:0]         mem_q [NUM_DATA_REG];

  logic                wr_en_c, ctrl_wr_c, thresh_wr_c, done_clr_c, is_data_c, mem_wr_c;
  logic                lvl_raw_c, lvl_c, edge_c, tick_c, timeout_hit_c, sym_we_c;
  logic [PRESC_W-1:0]  presc_mask_c;
  logic [DUR_W-1:0]    thr_c;
  logic [SYM_W-1:0]    sym_c;
  logic                unused_rd;

  assign unused_rd = ^data_read_n;

  // Bus write decode; data memory is writable only while not receiving
  assign wr_en_c     = (data_write_n == 2'b10);
  assign ctrl_wr_c   = wr_en_c && (address == ADDR_CTRL);
  assign thresh_wr_c = wr_en_c && (address == ADDR_THRESH);
  assign done_clr_c  = wr_en_c && (address == ADDR_STATUS) && data_in[0];
  assign is_data_c   = address[5] && (address[1:0] == 2'b00);
  assign mem_wr_c    = wr_en_c && is_data_c &&
                       ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Selected, optionally inverted, optionally filtered level
  assign lvl_raw_c = ui_in[ctrl_q.sel] ^ ctrl_q.invert;

`ifdef PULSE_RECEIVER_GLITCH_FILTER_EN
  pulse_receiver_glitch_filter #(
    .GLITCH_CYCLES (GLITCH_CYCLES)
  ) u_glitch_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_in   (lvl_raw_c),
    .filt_out (lvl_c)
  );
`else
  assign lvl_c = lvl_raw_c;
`endif

  assign edge_c = (lvl_c != prev_lvl_q);

  // One tick per 2^p clocks; >= lets the counter recover if p shrinks mid-count
  assign presc_mask_c = PRESC_W'((32'd1 << ctrl_q.presc) - 32'd1);
  assign tick_c       = (presc_q >= presc_mask_c);

  always_comb begin
    presc_d = presc_q + PRESC_W'(1);
    dur_d   = dur_q;
    if (edge_c) begin
      presc_d = '0;
      dur_d   = '0;
    end else if (tick_c) begin
      presc_d = '0;
      if (dur_q != '1) begin
        dur_d = dur_q + DUR_W'(1);
      end
    end
  end

  // Symbol of the pulse that just ended; equal to threshold classifies as short
  assign thr_c         = prev_lvl_q ? thresh_q.high_thr : thresh_q.low_thr;
  assign sym_c         = {prev_lvl_q, (dur_q > thr_c)};
  assign timeout_hit_c = tick_c && (thresh_q.idle_timeout != '0) &&
                         (dur_q == thresh_q.idle_timeout);

  // Receiver FSM; edges take priority over timeout, done-set over CPU clear
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    full_d   = full_q;
    done_d   = done_q & ~done_clr_c;
    sym_we_c = 1'b0;
    if (!ctrl_q.enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARMED;
          count_d = '0;
          full_d  = 1'b0;
        end
        ST_ARMED: begin
          if (edge_c) begin
            state_d = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (edge_c) begin
            sym_we_c = 1'b1;
            count_d  = count_q + COUNT_W'(1);
            if (count_q == COUNT_W'(CAPACITY - 1)) begin
              state_d = ST_DONE;
              full_d  = 1'b1;
              done_d  = 1'b1;
            end
          end else if (timeout_hit_c) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      thresh_q   <= '0;
      state_q    <= ST_IDLE;
      count_q    <= '0;
      full_q     <= 1'b0;
      done_q     <= 1'b0;
      prev_lvl_q <= 1'b0;
      presc_q    <= '0;
      dur_q      <= '0;
    end else begin
      if (ctrl_wr_c) begin
        ctrl_q <= ctrl_t'(data_in[CTRL_W-1:0]);
      end
      if (thresh_wr_c) begin
        thresh_q <= thresh_t'(data_in[THRESH_W-1:0]);
      end
      state_q    <= state_d;
      count_q    <= count_d;
      full_q     <= full_d;
      done_q     <= done_d;
      prev_lvl_q <= lvl_c;
      presc_q    <= presc_d;
      dur_q      <= dur_d;
    end
  end

  // Symbol memory (not reset); symbol n lands in word n[6:4], bits 2*n[3:0]
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(NUM_DATA_REG); k++) begin
      if (sym_we_c && (count_q[6:4] == 3'(k))) begin
        mem_q[k][{count_q[3:0], 1'b0} +: SYM_W] <= sym_c;
      end else if (mem_wr_c && (address[4:2] == 3'(k))) begin
        mem_q[k] <= data_in;
      end
    end
  end

  // Read mux; unimplemented addresses read 0
  always_comb begin
    data_out = '0;
    if (address == ADDR_CTRL) begin
      data_out = 32'(ctrl_q);
    end else if (address == ADDR_THRESH) begin
      data_out = 32'(thresh_q);
    end else if (address == ADDR_STATUS) begin
      data_out = 32'({state_q, count_q, full_q, done_q});
    end else if (is_data_c) begin
      for (int k = 0; k < int'(NUM_DATA_REG); k++) begin
        if (address[4:2] == 3'(k)) begin
          data_out = mem_q[k];
        end
      end
    end
  end

  assign uo_out         = '0;
  assign data_ready     = 1'b1;
  assign user_interrupt = done_q & ctrl_q.int_en;

endmodule

// File: tb/tb_tqvp_hx2003_pulse_receiver.sv
// Self-checking bench for tqvp_hx2003_pulse_receiver. Each driven pulse pushes its
// expected symbol to a scoreboard queue; symbols are popped and compared against the
// data memory once the receiver has stored them.
module tb_tqvp_hx2003_pulse_receiver;

  localparam int NREG = 5;
  localparam int CAP  = 16 * NREG;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  tqvp_hx2003_pulse_receiver dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt)
  );

  always #5 clk = ~clk;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [1:0] exp_q[$];
  int         plens[$];

  int         lo_thr, hi_thr, presc;
  logic [2:0] pin_sel;
  bit         inv;
  bit         idle_lvl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic hold(input int n);
    if (n > 0) repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [5:0] a, input logic [31:0] d);
    address      = a;
    data_in      = d;
    data_write_n = 2'b10;
    @(posedge clk);
    #1;
    data_write_n = 2'b11;
  endtask

  task automatic bus_rd(input logic [5:0] a, output logic [31:0] v);
    address = a;
    @(negedge clk);
    v = data_out;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit l);
    ui_in          = 8'($urandom);
    ui_in[pin_sel] = l ^ inv;
  endtask

  function automatic logic [31:0] ctrl_word(input bit en);
    return 32'(en) | (32'(inv) << 1) | (32'(pin_sel) << 2) | (32'd1 << 5) | (32'(presc) << 6);
  endfunction

  // Reference classifier: ticks between edges, saturating, strictly-greater is long
  function automatic logic [1:0] sym(input bit l, input int n);
    int d;
    int thr;
    d   = (n - 1) >> presc;
    if (d > 255) d = 255;
    thr = l ? hi_thr : lo_thr;
    return {l, (d > thr) ? 1'b1 : 1'b0};
  endfunction

  task automatic configure(input int p, input logic [2:0] sel, input bit iv,
                           input int lo, input int hi, input int to);
    bus_wr(6'h00, 32'd0);
    bus_wr(6'h08, 32'd1);
    presc = p; pin_sel = sel; inv = iv; lo_thr = lo; hi_thr = hi;
    idle_lvl = 1'b1;
    drive(1'b1);
    hold(8);
    bus_wr(6'h04, 32'(to) << 16 | 32'(hi) << 8 | 32'(lo));
    bus_wr(6'h00, ctrl_word(1'b1));
    hold(3);
  endtask

  // act 1: CPU data write at start of pulse act_idx; act 2: state check right after its edge
  task automatic run_pulses(input int max_store, input int act_idx, input int act);
    bit l;
    logic [31:0] st;
    l = idle_lvl;
    for (int i = 0; i < plens.size(); i++) begin
      l = ~l;
      drive(l);
      if (i == act_idx && act == 1) begin
        bus_wr(6'h20, 32'hDEADBEEF);
        hold(plens[i] - 1);
      end else if (i == act_idx && act == 2) begin
        hold(1);
        bus_rd(6'h08, st);
        check("t2 state after edge at timeout", 32'(st[11:10]), 32'd2);
        check("t2 done after edge at timeout", 32'(st[0]), 32'd0);
        hold(plens[i] - 2);
      end else begin
        hold(plens[i]);
      end
      if (i < max_store) exp_q.push_back(sym(l, plens[i]));
    end
    l = ~l;
    drive(l);
    idle_lvl = l;
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] st;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      bus_rd(6'h08, st);
      if (st[0]) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic check_syms(input string tag);
    logic [31:0] st;
    logic [31:0] w[NREG];
    logic [31:0] wd;
    logic [1:0]  e;
    int          n;
    n = exp_q.size();
    bus_rd(6'h08, st);
    check($sformatf("%s count", tag), 32'(st[9:2]), 32'(n));
    for (int k = 0; k < NREG; k++) bus_rd(6'(32 + 4 * k), w[k]);
    for (int i = 0; i < n; i++) begin
      e  = exp_q.pop_front();
      wd = w[i / 16];
      check($sformatf("%s sym%0d", tag, i), 32'(wd[2 * (i % 16) +: 2]), 32'(e));
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    rst_n = 1'b0; ui_in = '0; address = '0; data_in = '0;
    data_write_n = 2'b11; data_read_n = 2'b11;
    presc = 0; pin_sel = '0; inv = 1'b0; lo_thr = 0; hi_thr = 0; idle_lvl = 1'b0;
    hold(4);
    rst_n = 1'b1;
    hold(1);

    // Reset state
    bus_rd(6'h00, v); check("reset ctrl", v, 32'd0);
    bus_rd(6'h04, v); check("reset thresh", v, 32'd0);
    bus_rd(6'h08, v); check("reset status", v, 32'd0);
    check("reset irq", 32'(user_interrupt), 32'd0);

    // T1: basic sequence ending on idle timeout
    configure(0, 3'd0, 1'b0, 10, 10, 50);
    plens = '{5, 20, 30, 8};
    run_pulses(CAP, -1, 0);
    wait_done("t1 done timeout");
    bus_rd(6'h20, v); check("t1 word0 low byte", 32'(v[7:0]), 32'h9C);
    bus_rd(6'h08, v);
    check("t1 full", 32'(v[1]), 32'd0);
    check("t1 state", 32'(v[11:10]), 32'd3);
    check("t1 irq", 32'(user_interrupt), 32'd1);
    check_syms("t1");
    bus_wr(6'h08, 32'd1);
    bus_rd(6'h08, v);
    check("t1 done cleared", 32'(v[0]), 32'd0);
    check("t1 irq cleared", 32'(user_interrupt), 32'd0);

    // T2: threshold boundaries and an edge landing on the timeout tick (p=1, inverted pin 5)
    configure(1, 3'd5, 1'b1, 10, 10, 50);
    plens = '{22, 24, 102, 6};
    run_pulses(CAP, 3, 2);
    wait_done("t2 done timeout");
    check_syms("t2");

    // T3: fill the buffer, CPU write during MEASURE dropped, write in DONE accepted
    configure(0, 3'd2, 1'b0, 10, 10, 50);
    plens = {};
    for (int i = 0; i < CAP + 1; i++) plens.push_back(int'($urandom_range(5, 24)));
    run_pulses(CAP, 1, 1);
    wait_done("t3 done full");
    bus_rd(6'h08, v);
    check("t3 full", 32'(v[1]), 32'd1);
    check("t3 state", 32'(v[11:10]), 32'd3);
    check_syms("t3");
    bus_wr(6'h20, 32'hDEADBEEF);
    bus_rd(6'h20, v); check("t3 cpu write in done", v, 32'hDEADBEEF);

    // T4: saturated duration with no timeout, then abort and re-arm
    configure(0, 3'd7, 1'b0, 10, 10, 0);
    plens = '{300, 5, 23};
    run_pulses(CAP, -1, 0);
    hold(3);
    bus_wr(6'h00, ctrl_word(1'b0));
    hold(1);
    bus_rd(6'h08, v);
    check("t4 abort state", 32'(v[11:10]), 32'd0);
    check("t4 abort done", 32'(v[0]), 32'd0);
    check_syms("t4");
    bus_wr(6'h00, ctrl_word(1'b1));
    hold(1);
    bus_rd(6'h08, v);
    check("t4 rearm count", 32'(v[9:2]), 32'd0);
    check("t4 rearm state", 32'(v[11:10]), 32'd1);

    // T6: 2-clock glitch inside a low pulse
    configure(0, 3'd0, 1'b0, 10, 10, 50);
    plens = '{10, 2, 10};
`ifdef PULSE_RECEIVER_GLITCH_FILTER_EN
    run_pulses(0, -1, 0);
    exp_q.push_back(sym(1'b0, 22));
`else
    run_pulses(CAP, -1, 0);
`endif
    wait_done("t6 done timeout");
    check_syms("t6");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
